health_control: RTL

Per-combatant health and death tracker driven by the frame clock. It takes hit events from the collision/attack logic, keeps saturating HP counters and post-hit invulnerability windows for the player and the NPC, and produces the `Player_Dead` / `NPC_Dead` levels consumed by the stage controller. Each dead flag is held for a fixed number of frames and then released, so the stage controller can show the win/lose screen and then fall back to START. HP is reloaded whenever the stage controller reports the start screen.

---
 rtl/health_control.sv | 117 +++++++++++
 1 files changed

// File: rtl/health_control.sv
// Player/NPC health tracker: saturating HP, post-hit invulnerability windows,
// and timed death holds, with a shared "over" latch that freezes combat after a kill.
module health_control #(
  parameter int unsigned MAX_HP     = 100,
  parameter int unsigned HP_W       = 7,
  parameter int unsigned IFRAMES    = 30,
  parameter int unsigned DEATH_HOLD = 120
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start_l,
  input  logic            battle_l,
  input  logic            Player_Hit,
  input  logic [HP_W-1:0] Player_Dmg,
  input  logic            NPC_Hit,
  input  logic [HP_W-1:0] NPC_Dmg,
  output logic [HP_W-1:0] Player_HP,
  output logic [HP_W-1:0] NPC_HP,
  output logic            Player_Invuln,
  output logic            NPC_Invuln,
  output logic            Player_Dead,
  output logic            NPC_Dead
);

  localparam int unsigned IW = $clog2(IFRAMES + 1);
  localparam int unsigned DW = $clog2(DEATH_HOLD + 1);

  typedef enum logic [1:0] {StAlive, StInvuln, StDead, StDone} side_st_e;

  // Index 0 is the player, index 1 the NPC.
  side_st_e        st_q   [2];
  logic [HP_W-1:0] hp_q   [2];
  logic [IW-1:0]   icnt_q [2];
  logic [DW-1:0]   dcnt_q [2];
  logic            inv_q  [2];
  logic            dead_q [2];
  logic            over_q;

  logic            hit    [2];
  logic [HP_W-1:0] dmg    [2];
  logic            accept [2];
  logic            fatal  [2];

  always_comb begin
    hit[0] = Player_Hit;
    hit[1] = NPC_Hit;
    dmg[0] = Player_Dmg;
    dmg[1] = NPC_Dmg;
    for (int i = 0; i < 2; i++) begin
      // Zero damage is treated as no hit at all.
      accept[i] = hit[i] && battle_l && !over_q && (st_q[i] == StAlive) &&
                  (dmg[i] != '0);
      fatal[i]  = accept[i] && (dmg[i] >= hp_q[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset || start_l) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= StAlive;
        hp_q[i]   <= HP_W'(MAX_HP);
        icnt_q[i] <= '0;
        dcnt_q[i] <= '0;
        inv_q[i]  <= 1'b0;
        dead_q[i] <= 1'b0;
      end
      over_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case (st_q[i])
          StAlive: begin
            if (fatal[i]) begin
              st_q[i]   <= StDead;
              hp_q[i]   <= '0;
              dcnt_q[i] <= DW'(DEATH_HOLD);
              dead_q[i] <= 1'b1;
            end else if (accept[i]) begin
              st_q[i]   <= StInvuln;
              hp_q[i]   <= hp_q[i] - dmg[i];
              icnt_q[i] <= IW'(IFRAMES);
              inv_q[i]  <= 1'b1;
            end
          end
          StInvuln: begin
            if (icnt_q[i] == IW'(1)) begin
              st_q[i]   <= StAlive;
              icnt_q[i] <= '0;
              inv_q[i]  <= 1'b0;
            end else begin
              icnt_q[i] <= icnt_q[i] - IW'(1);
            end
          end
          StDead: begin
            if (dcnt_q[i] == DW'(1)) begin
              st_q[i]   <= StDone;
              dcnt_q[i] <= '0;
              dead_q[i] <= 1'b0;
            end else begin
              dcnt_q[i] <= dcnt_q[i] - DW'(1);
            end
          end
          StDone: ;
          default: st_q[i] <= StAlive;
        endcase
      end
      over_q <= over_q | fatal[0] | fatal[1];
    end
  end

  assign Player_HP     = hp_q[0];
  assign NPC_HP        = hp_q[1];
  assign Player_Invuln = inv_q[0];
  assign NPC_Invuln    = inv_q[1];
  assign Player_Dead   = dead_q[0];
  assign NPC_Dead      = dead_q[1];

endmodule
